// File: rtl/vgpr_wb_scheduler.sv
// rtl/vgpr_wb_scheduler.sv - VGPR writeback scheduler: VALU round-robin on wr0, LSU bursts on wr1
module vgpr_wb_scheduler #(
  parameter int ADDR_W = 10,
  parameter int LANES  = 64,
  parameter int MAX_DW = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valu0_wb_valid,
  output logic                    valu0_wb_ready,
  input  logic [ADDR_W-1:0]       valu0_wb_addr,
  input  logic [LANES-1:0]        valu0_wb_exec,
  input  logic [32*LANES-1:0]     valu0_wb_data,
  input  logic                    valu1_wb_valid,
  output logic                    valu1_wb_ready,
  input  logic [ADDR_W-1:0]       valu1_wb_addr,
  input  logic [LANES-1:0]        valu1_wb_exec,
  input  logic [32*LANES-1:0]     valu1_wb_data,
  input  logic                    lsu_wb_valid,
  input  logic [ADDR_W-1:0]       lsu_wb_addr,
  input  logic [4:0]              lsu_wb_count,
  input  logic [LANES-1:0]        lsu_wb_exec,
  input  logic [128*LANES-1:0]    lsu_wb_data,
  output logic                    lsu_beat_ack,
  output logic                    lsu_wb_done,
  output logic                    lsu_wb_err,
  output logic [LANES-1:0]        wr0_en,
  output logic [ADDR_W-1:0]       wr0_addr,
  output logic [32*LANES-1:0]     wr0_data,
  output logic [LANES-1:0]        wr1_en,
  output logic [3:0]              wr1_en_xoutof4,
  output logic [ADDR_W-1:0]       wr1_addr,
  output logic [128*LANES-1:0]    wr1_data
);

  typedef enum logic [1:0] {IDLE, BURST, ERR} lsu_state_t;

  lsu_state_t          state, state_nxt;
  logic [ADDR_W-1:0]   beat_addr;
  logic [4:0]          remaining;
  logic [2:0]          beat_n;
  logic [3:0]          beat_mask;
  logic [ADDR_W:0]     beat_last;
  logic [ADDR_W:0]     burst_end;
  logic                burst_bad;
  logic                beat;
  logic                rr_ptr;
  logic                win_sel;
  logic                win_valid;
  logic [ADDR_W-1:0]   win_addr;
  logic                collide;
  logic                grant;

  // Burst legality: zero/oversized counts and ranges running past the last VGPR
  always_comb begin
    burst_end = {1'b0, lsu_wb_addr} + (ADDR_W+1)'(lsu_wb_count) - (ADDR_W+1)'(1);
    burst_bad = (lsu_wb_count == 5'd0) || (lsu_wb_count > 5'(MAX_DW)) ||
                (burst_end > {1'b0, {ADDR_W{1'b1}}});
  end

  // Current beat size, dword mask and covered address range
  always_comb begin
    beat_n    = (remaining >= 5'd4) ? 3'd4 : remaining[2:0];
    beat_last = {1'b0, beat_addr} + (ADDR_W+1)'(beat_n) - (ADDR_W+1)'(1);
    case (beat_n)
      3'd1:    beat_mask = 4'b0001;
      3'd2:    beat_mask = 4'b0011;
      3'd3:    beat_mask = 4'b0111;
      3'd4:    beat_mask = 4'b1111;
      default: beat_mask = 4'b0000;
    endcase
  end

  // LSU FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // LSU FSM next state and handshake pulses
  always_comb begin
    state_nxt    = state;
    beat         = 1'b0;
    lsu_beat_ack = 1'b0;
    lsu_wb_done  = 1'b0;
    lsu_wb_err   = 1'b0;
    case (state)
      IDLE: begin
        if (lsu_wb_valid) state_nxt = burst_bad ? ERR : BURST;
      end
      BURST: begin
        beat         = 1'b1;
        lsu_beat_ack = 1'b1;
        if (remaining <= 5'd4) begin
          lsu_wb_done = 1'b1;
          state_nxt   = IDLE;
        end
      end
      ERR: begin
        lsu_wb_err = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Burst address and dword countdown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_addr <= '0;
      remaining <= '0;
    end else if (state == IDLE && lsu_wb_valid && !burst_bad) begin
      beat_addr <= lsu_wb_addr;
      remaining <= lsu_wb_count;
    end else if (beat) begin
      beat_addr <= beat_addr + ADDR_W'(4);
      remaining <= remaining - 5'(beat_n);
    end
  end

  // VALU winner selection; the LSU beat always wins an address overlap
  always_comb begin
    win_valid = valu0_wb_valid || valu1_wb_valid;
    if (valu0_wb_valid && valu1_wb_valid) win_sel = rr_ptr;
    else                                  win_sel = valu1_wb_valid;
    win_addr = win_sel ? valu1_wb_addr : valu0_wb_addr;
    collide  = beat && (win_addr >= beat_addr) && ({1'b0, win_addr} <= beat_last);
    grant    = rst_n && win_valid && !collide;
    valu0_wb_ready = grant && !win_sel;
    valu1_wb_ready = grant && win_sel;
  end

  // Round-robin pointer favours the source that did not just win
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rr_ptr <= 1'b0;
    else if (grant) rr_ptr <= ~win_sel;
  end

  // Port 0 write registers; address and data hold while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr0_en   <= '0;
      wr0_addr <= '0;
      wr0_data <= '0;
    end else if (grant) begin
      wr0_en   <= win_sel ? valu1_wb_exec : valu0_wb_exec;
      wr0_addr <= win_addr;
      wr0_data <= win_sel ? valu1_wb_data : valu0_wb_data;
    end else begin
      wr0_en   <= '0;
    end
  end

  // Port 1 write registers; one beat per cycle while in BURST
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr1_en         <= '0;
      wr1_en_xoutof4 <= '0;
      wr1_addr       <= '0;
      wr1_data       <= '0;
    end else if (beat) begin
      wr1_en         <= lsu_wb_exec;
      wr1_en_xoutof4 <= beat_mask;
      wr1_addr       <= beat_addr;
      wr1_data       <= lsu_wb_data;
    end else begin
      wr1_en         <= '0;
      wr1_en_xoutof4 <= '0;
    end
  end

endmodule
